// File: rtl/keccak_byte_packer.sv
// rtl/keccak_byte_packer.sv - packs a byte stream big-endian into 32-bit words with keccak is_last/byte_num framing
// Optional byte counter output msg_len is built only when KECCAK_PACKER_LEN_EN is defined.
`timescale 1ns/1ps
module keccak_byte_packer #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_empty,
  output logic             s_ready,
  output logic [31:0]      k_in,
  output logic             k_in_ready,
  output logic             k_is_last,
  output logic [1:0]       k_byte_num,
  input  logic             k_buffer_full,
  output logic             done
`ifdef KECCAK_PACKER_LEN_EN
  ,
  output logic [LEN_W-1:0] msg_len
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_TAIL, ST_LAST, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0]  acc_cnt_q, acc_cnt_d;
  logic [31:0] k_in_q, k_in_d;
  logic        out_valid_q, out_valid_d;
  logic        is_last_q, is_last_d;
  logic [1:0]  byte_num_q, byte_num_d;
  logic        done_q, done_d;
  logic        out_fire, accept;
  logic [31:0] merged;
`ifdef KECCAK_PACKER_LEN_EN
  logic [LEN_W-1:0] len_q, len_d;
`endif

  always_comb begin
    out_fire = out_valid_q & ~k_buffer_full;
    s_ready  = (state_q == ST_RUN) & (~out_valid_q | out_fire);
    accept   = s_valid & s_ready;

    // Unfilled accumulator slots are always zero, so this is also the zero-padded word.
    merged = {acc_q, 8'h00};
    case (acc_cnt_q)
      2'd0:    merged[31:24] = s_byte;
      2'd1:    merged[23:16] = s_byte;
      2'd2:    merged[15:8]  = s_byte;
      default: merged[7:0]   = s_byte;
    endcase

    state_d     = state_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    k_in_d      = k_in_q;
    out_valid_d = out_valid_q;
    is_last_d   = is_last_q;
    byte_num_d  = byte_num_q;
    done_d      = done_q;

    if (out_fire) out_valid_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (s_last && s_empty) begin
            k_in_d      = {acc_q, 8'h00};
            byte_num_d  = acc_cnt_q;
            is_last_d   = 1'b1;
            out_valid_d = 1'b1;
            acc_d       = 24'h0;
            acc_cnt_d   = 2'd0;
            state_d     = ST_LAST;
          end else if (s_last || acc_cnt_q == 2'd3) begin
            k_in_d      = merged;
            out_valid_d = 1'b1;
            acc_d       = 24'h0;
            acc_cnt_d   = 2'd0;
            is_last_d   = 1'b0;
            byte_num_d  = 2'd0;
            if (s_last && acc_cnt_q == 2'd3) begin
              // Length multiple of 4: the core still needs an empty final word.
              state_d = ST_TAIL;
            end else if (s_last) begin
              is_last_d  = 1'b1;
              byte_num_d = acc_cnt_q + 2'd1;
              state_d    = ST_LAST;
            end
          end else begin
            acc_d     = merged[31:8];
            acc_cnt_d = acc_cnt_q + 2'd1;
          end
        end
      end
      ST_TAIL: begin
        if (out_fire) begin
          k_in_d      = 32'h0;
          is_last_d   = 1'b1;
          byte_num_d  = 2'd0;
          out_valid_d = 1'b1;
          state_d     = ST_LAST;
        end
      end
      ST_LAST: begin
        if (out_fire) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: ;
    endcase

`ifdef KECCAK_PACKER_LEN_EN
    len_d = len_q;
    if (accept && !(s_last && s_empty) && len_q != {LEN_W{1'b1}})
      len_d = len_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      acc_q       <= 24'h0;
      acc_cnt_q   <= 2'd0;
      k_in_q      <= 32'h0;
      out_valid_q <= 1'b0;
      is_last_q   <= 1'b0;
      byte_num_q  <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      k_in_q      <= k_in_d;
      out_valid_q <= out_valid_d;
      is_last_q   <= is_last_d;
      byte_num_q  <= byte_num_d;
      done_q      <= done_d;
    end
  end

`ifdef KECCAK_PACKER_LEN_EN
  always_ff @(posedge clk) begin
    if (reset) len_q <= '0;
    else       len_q <= len_d;
  end
  assign msg_len = len_q;
`endif

  assign k_in       = k_in_q;
  assign k_in_ready = out_valid_q;
  assign k_is_last  = is_last_q;
  assign k_byte_num = byte_num_q;
  assign done       = done_q;

endmodule

// File: tb/tb_keccak_byte_packer.sv
// tb/tb_keccak_byte_packer.sv - directed self-checking bench for keccak_byte_packer
`timescale 1ns/1ps
module tb_keccak_byte_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_byte = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_empty = 1'b0;
  logic        s_ready;
  logic [31:0] k_in;
  logic        k_in_ready;
  logic        k_is_last;
  logic [1:0]  k_byte_num;
  logic        k_buffer_full = 1'b0;
  logic        done;
`ifdef KECCAK_PACKER_LEN_EN
  logic [31:0] msg_len;
`endif

  keccak_byte_packer #(.LEN_W(32)) dut (
    .clk(clk), .reset(reset),
    .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last), .s_empty(s_empty), .s_ready(s_ready),
    .k_in(k_in), .k_in_ready(k_in_ready), .k_is_last(k_is_last), .k_byte_num(k_byte_num),
    .k_buffer_full(k_buffer_full), .done(done)
`ifdef KECCAK_PACKER_LEN_EN
    , .msg_len(msg_len)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int waits = 0;
  int stall_left = 0;
  logic [31:0] stall_word = 32'h0;
  logic [7:0]  msg[$];
  logic [34:0] words_q[$];

  // Values at the falling edge are the ones the next rising edge will act on.
  always @(negedge clk)
    if (!reset && k_in_ready && !k_buffer_full)
      words_q.push_back({k_is_last, k_byte_num, k_in});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; k_buffer_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    words_q.delete();
    waits = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic empty);
    bit accepted = 0;
    s_byte = b; s_valid = 1'b1; s_last = last; s_empty = empty;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (s_ready) begin accepted = 1; break; end
      waits++;
      if (stall_left > 0) begin
        chk("stall_k_in", k_in, stall_word);
        chk("stall_k_in_ready", k_in_ready, 1'b1);
        chk("stall_k_is_last", k_is_last, 1'b0);
        stall_left--;
      end
      @(posedge clk); #1;
      if (stall_left == 0) k_buffer_full = 1'b0;
    end
    chk("byte_accept", accepted, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
  endtask

  task automatic send_msg(input int stall_at);
    for (int i = 0; i < msg.size(); i++) begin
      if (i == stall_at) begin k_buffer_full = 1'b1; stall_left = 5; end
      send_byte(msg[i], i == msg.size() - 1, 1'b0);
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done", done, 1'b1);
    chk("done_k_in_ready", k_in_ready, 1'b0);
    chk("done_s_ready", s_ready, 1'b0);
  endtask

  // Every message of L bytes yields L/4+1 words; the final one carries L%4 bytes.
  task automatic check_words(input string tag);
    int n = msg.size() / 4 + 1;
    chk({tag, "_word_count"}, words_q.size(), n);
    for (int k = 0; k < n && k < words_q.size(); k++) begin
      logic [31:0] w = 32'h0;
      logic [1:0]  bn = 2'd0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < msg.size()) w[31 - 8 * j -: 8] = msg[4 * k + j];
      if (k == n - 1) bn = 2'(msg.size() % 4);
      chk($sformatf("%s_word%0d", tag, k), words_q[k], {k == n - 1, bn, w});
    end
  endtask

  task automatic load_string(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_k_in", k_in, 32'h0);
    chk("rst_k_in_ready", k_in_ready, 1'b0);
    chk("rst_k_is_last", k_is_last, 1'b0);
    chk("rst_k_byte_num", k_byte_num, 2'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
`ifdef KECCAK_PACKER_LEN_EN
    chk("rst_msg_len", msg_len, 32'd0);
`endif
    @(posedge clk); #1;

    // 43-byte pangram at full rate
    load_string("The quick brown fox jumps over the lazy dog");
    send_msg(-1);
    wait_done();
    chk("t1_no_wait", waits, 0);
    chk("t1_first", words_q.size() > 0 ? words_q[0] : 35'h0, {1'b0, 2'd0, 32'h54686520});
    chk("t1_last", words_q.size() > 10 ? words_q[10] : 35'h0, {1'b1, 2'd3, 32'h646F6700});
    check_words("t1");
`ifdef KECCAK_PACKER_LEN_EN
    chk("t1_msg_len", msg_len, 32'd43);
`endif

    // 44 bytes: trailing empty word
    do_reset();
    load_string("The quick brown fox jumps over the lazy dog.");
    send_msg(-1);
    wait_done();
    chk("t2_full", words_q.size() > 10 ? words_q[10] : 35'h0, {1'b0, 2'd0, 32'h646F672E});
    chk("t2_tail", words_q.size() > 11 ? words_q[11] : 35'h0, {1'b1, 2'd0, 32'h00000000});
    check_words("t2");
`ifdef KECCAK_PACKER_LEN_EN
    chk("t2_msg_len", msg_len, 32'd44);
`endif

    // Empty message via s_empty: the carried byte must be dropped
    do_reset();
    msg.delete();
    send_byte(8'h5A, 1'b1, 1'b1);
    wait_done();
    check_words("t3");
    s_byte = 8'h11; s_valid = 1'b1;
    @(negedge clk);
    chk("t3_after_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;
`ifdef KECCAK_PACKER_LEN_EN
    chk("t3_msg_len", msg_len, 32'd0);
`endif

    // A1..A5
    do_reset();
    msg = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_msg(-1);
    wait_done();
    chk("t4_w0", words_q.size() > 0 ? words_q[0] : 35'h0, {1'b0, 2'd0, 32'hA1A2A3A4});
    chk("t4_w1", words_q.size() > 1 ? words_q[1] : 35'h0, {1'b1, 2'd1, 32'hA5000000});
    chk("t4_count", words_q.size(), 2);
`ifdef KECCAK_PACKER_LEN_EN
    chk("t4_msg_len", msg_len, 32'd5);
`endif

    // 72 bytes with back-pressure while word 1 sits in the output register
    do_reset();
    msg.delete();
    for (int i = 0; i < 72; i++) begin
      case (i % 4)
        0: msg.push_back(8'(8'h90 + i / 4));
        1: msg.push_back(8'(8'hAB + i / 4));
        2: msg.push_back(8'(8'hCD + i / 4));
        default: msg.push_back(8'(8'hEF + i / 4));
      endcase
    end
    stall_word = 32'h91ACCEF0;
    send_msg(6);
    wait_done();
    chk("t5_stall_cycles", waits, 5);
    chk("t5_tail", words_q.size() > 18 ? words_q[18] : 35'h0, {1'b1, 2'd0, 32'h0});
    check_words("t5");
`ifdef KECCAK_PACKER_LEN_EN
    chk("t5_msg_len", msg_len, 32'd72);
`endif

    // Reset in the middle of a message
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hB0 + i), 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    chk("t6_rst_k_in_ready", k_in_ready, 1'b0);
    chk("t6_rst_k_in", k_in, 32'h0);
    @(posedge clk); #1;
    msg = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    send_msg(-1);
    wait_done();
    chk("t6_w0", words_q.size() > 0 ? words_q[0] : 35'h0, {1'b0, 2'd0, 32'hC1C2C3C4});
    check_words("t6");
`ifdef KECCAK_PACKER_LEN_EN
    chk("t6_msg_len", msg_len, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
